// File: rtl/set_injector_pkg.sv
// set_injector shared types: FSM states, command kinds, time units.
// Helpers parse scenario values and turn durations into clock cycles.
package tb_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RESTORE,
    DONE
  } set_state_t;

  typedef enum logic [1:0] {
    CMD_SET,
    CMD_PULSE,
    CMD_ERR
  } set_cmd_t;

  localparam longint SCALE_PS = 64'd1;
  localparam longint SCALE_NS = 64'd1_000;
  localparam longint SCALE_US = 64'd1_000_000;
  localparam longint SCALE_MS = 64'd1_000_000_000;

  localparam longint CYC_MAX = 64'h0000_0000_FFFF_FFFF;

  // Zero marks an unknown unit.
  function automatic longint unit_scale(string unit);
    if (unit == "ps") return SCALE_PS;
    if (unit == "ns") return SCALE_NS;
    if (unit == "us") return SCALE_US;
    if (unit == "ms") return SCALE_MS;
    return 64'd0;
  endfunction

  function automatic logic unit_ok(string unit);
    return unit_scale(unit) != 64'd0;
  endfunction

  // "0x" prefix selects hex, anything else is decimal.
  function automatic logic [31:0] parse_value(string s);
    string body;
    if (s.len() >= 2 && s.substr(0, 1) == "0x") begin
      body = s.substr(2, s.len() - 1);
      return body.atohex();
    end
    return s.atoi();
  endfunction

  // Floor-divided cycle count, clamped to 1, saturated to 32 bits.
  function automatic logic [31:0] time_to_cycles(
    longint dur,
    string  unit,
    int     clk_period
  );
    longint d;
    d = (dur * unit_scale(unit)) / longint'(clk_period);
    if (d < 64'sd1) return 32'd1;
    if (d > CYC_MAX) return 32'hFFFF_FFFF;
    return d[31:0];
  endfunction

endpackage

// File: rtl/set_injector_if.sv
// Sequencer <-> set_injector bundle: alias table, select/args command
// port, driven slots, done and error pulses.
interface set_injector_if #(
  parameter int ARGS_NB   = 5,
  parameter int SET_SIZE  = 5,
  parameter int SET_WIDTH = 1
);

  string                i_set_alias [SET_SIZE];
  logic                 i_sel_set;
  logic                 i_args_valid;
  string                i_args [ARGS_NB];
  logic [SET_WIDTH-1:0] o_set [SET_SIZE];
  logic                 o_set_done;
  logic                 o_error;

  modport master (
    output i_set_alias,
    output i_sel_set,
    output i_args_valid,
    output i_args,
    input  o_set,
    input  o_set_done,
    input  o_error
  );

  modport slave (
    input  i_set_alias,
    input  i_sel_set,
    input  i_args_valid,
    input  i_args,
    output o_set,
    output o_set_done,
    output o_error
  );

endinterface

// File: rtl/set_injector.sv
// set_injector: runs SET / PULSE scenario commands onto named slots.
// Ports: clk, rst (sync, high), bus (set_injector_if.slave).
module set_injector
  import tb_cmd_pkg::*;
#(
  parameter int ARGS_NB    = 5,
  parameter int SET_SIZE   = 5,
  parameter int SET_WIDTH  = 1,
  parameter int CLK_PERIOD = 1000
) (
  input logic          clk,
  input logic          rst,
  set_injector_if.slave bus
);

  localparam int SW = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1;

  set_state_t           state;
  set_cmd_t             kind_q;
  logic                 pend;
  logic                 err_q;
  logic [SW-1:0]        slot_q;
  logic [SET_WIDTH-1:0] val_q;
  logic [SET_WIDTH-1:0] saved_q;
  logic [31:0]          cnt;

  string alias_map [SET_SIZE];

  string a_cmd;
  string a_alias;
  string a_val;
  string a_dur;
  string a_unit;

  set_cmd_t             dec_kind;
  logic [SW-1:0]        dec_slot;
  logic [SET_WIDTH-1:0] dec_val;
  logic [31:0]          dec_cyc;
  logic                 hit;
  logic                 accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SET_SIZE; i++)
        alias_map[i] <= bus.i_set_alias[i];
    end
  end

  always_comb begin
    a_cmd   = bus.i_args[0];
    a_alias = bus.i_args[1];
    a_val   = bus.i_args[2];
    a_dur   = bus.i_args[3];
    a_unit  = bus.i_args[4];
  end

  always_comb begin
    dec_kind = CMD_ERR;
    dec_slot = '0;
    dec_cyc  = 32'd1;
    hit      = 1'b0;
    dec_val  = SET_WIDTH'(parse_value(a_val));
    for (int i = 0; i < SET_SIZE; i++) begin
      if (!hit && a_alias.len() != 0 &&
          alias_map[i] == a_alias) begin
        hit      = 1'b1;
        dec_slot = SW'(i);
      end
    end
    if (hit && a_val.len() != 0) begin
      if (a_cmd == "SET") begin
        dec_kind = CMD_SET;
      end else if (a_cmd == "PULSE" &&
                   a_dur.len() != 0 &&
                   unit_ok(a_unit)) begin
        dec_kind = CMD_PULSE;
        dec_cyc  = time_to_cycles(
          longint'(a_dur.atoi()), a_unit, CLK_PERIOD);
      end
    end
  end

  // pend marks the cycle between sampling a command and acting on it.
  assign accept = bus.i_sel_set && bus.i_args_valid &&
                  state == IDLE && !pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pend   <= 1'b0;
      err_q  <= 1'b0;
      kind_q <= CMD_SET;
      slot_q <= '0;
      val_q  <= '0;
    end else begin
      pend <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pend) begin
            state <= DONE;
          end else if (accept) begin
            pend   <= 1'b1;
            kind_q <= dec_kind;
            slot_q <= dec_slot;
            val_q  <= dec_val;
            err_q  <= dec_kind == CMD_ERR;
            if (dec_kind == CMD_PULSE)
              state <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == 32'd1)
            state <= RESTORE;
        end
        RESTORE: state <= DONE;
        DONE:    state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= dec_cyc;
    end else if (state == HOLD && cnt > 32'd1) begin
      cnt <= cnt - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SET_SIZE; i++)
        bus.o_set[i] <= '0;
      saved_q        <= '0;
      bus.o_set_done <= 1'b0;
      bus.o_error    <= 1'b0;
    end else begin
      bus.o_set_done <= state == DONE;
      bus.o_error    <= state == DONE && err_q;
      if (pend && kind_q != CMD_ERR) begin
        saved_q           <= bus.o_set[slot_q];
        bus.o_set[slot_q] <= val_q;
      end
      if (state == RESTORE)
        bus.o_set[slot_q] <= saved_q;
    end
  end

endmodule

// File: tb/tb_set_injector.sv
// Self-checking bench for set_injector.
// Random and directed SET/PULSE traffic against a timeline model.
module tb_set_injector;

  localparam int ARGS_NB    = 5;
  localparam int SET_SIZE   = 5;
  localparam int SET_WIDTH  = 4;
  localparam int CLK_PERIOD = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic [SET_WIDTH-1:0] mdl [SET_SIZE];

  set_injector_if #(
    .ARGS_NB  (ARGS_NB),
    .SET_SIZE (SET_SIZE),
    .SET_WIDTH(SET_WIDTH)
  ) bus ();

  set_injector #(
    .ARGS_NB   (ARGS_NB),
    .SET_SIZE  (SET_SIZE),
    .SET_WIDTH (SET_WIDTH),
    .CLK_PERIOD(CLK_PERIOD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Pulse length from the time rules: duration in ps over the period.
  function automatic int cycles_of(int dur, string unit);
    longint ps;
    longint d;
    ps = longint'(dur);
    if (unit == "ns") ps = ps * 1000;
    if (unit == "us") ps = ps * 1000000;
    if (unit == "ms") ps = ps * 1000000000;
    d = ps / CLK_PERIOD;
    if (d == 0) d = 1;
    return int'(d);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(string c, string a, string v,
                       string d, string u);
    bus.i_args[0]    = c;
    bus.i_args[1]    = a;
    bus.i_args[2]    = v;
    bus.i_args[3]    = d;
    bus.i_args[4]    = u;
    bus.i_sel_set    = 1'b1;
    bus.i_args_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_args_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      for (int s = 0; s < SET_SIZE; s++) begin
        checks++;
        if (bus.o_set[s] !== '0) begin
          failures++;
          $display("FAIL reset_set%0d got=%0h exp=0",
                   s, bus.o_set[s]);
        end
      end
      checks++;
      if (bus.o_set_done !== 1'b0 || bus.o_error !== 1'b0) begin
        failures++;
        $display("FAIL reset_flags got=%b%b exp=00",
                 bus.o_set_done, bus.o_error);
      end
    end
    rst = 1'b0;
    for (int s = 0; s < SET_SIZE; s++) mdl[s] = '0;
  endtask

  task automatic test_set();
    string ta [2] = '{"sig1", "sig4"};
    string tv [2] = '{"1", "0x15"};
    int    ts [2] = '{1, 4};
    int    te [2] = '{1, 5};
    logic [SET_WIDTH-1:0] e [SET_SIZE];
    for (int t = 0; t < 2; t++) begin
      issue("SET", ta[t], tv[t], "", "");
      e = mdl;
      e[ts[t]] = SET_WIDTH'(te[t]);
      for (int k = 1; k <= 3; k++) begin
        step();
        for (int s = 0; s < SET_SIZE; s++) begin
          checks++;
          if (bus.o_set[s] !== e[s]) begin
            failures++;
            $display("FAIL set%0d_k%0d_slot%0d got=%0h exp=%0h",
                     t, k, s, bus.o_set[s], e[s]);
          end
        end
        checks++;
        if (bus.o_set_done !== (k == 2) || bus.o_error !== 1'b0) begin
          failures++;
          $display("FAIL set%0d_done_k%0d got=%b%b exp=%b0",
                   t, k, bus.o_set_done, bus.o_error, k == 2);
        end
      end
      mdl = e;
    end
  endtask

  task automatic test_pulse();
    string ta [4] = '{"sig0", "sig2", "sig3", "sig1"};
    string tv [4] = '{"0x5", "1", "7", "9"};
    string td [4] = '{"10", "300", "2999", "1"};
    string tu [4] = '{"ns", "ps", "ps", "us"};
    int    ts [4] = '{0, 2, 3, 1};
    int    tn [4] = '{5, 1, 7, 9};
    logic [SET_WIDTH-1:0] e [SET_SIZE];
    int d;
    for (int t = 0; t < 4; t++) begin
      d = cycles_of(td[t].atoi(), tu[t]);
      issue("PULSE", ta[t], tv[t], td[t], tu[t]);
      for (int k = 1; k <= d + 3; k++) begin
        step();
        e = mdl;
        if (k <= d) e[ts[t]] = SET_WIDTH'(tn[t]);
        for (int s = 0; s < SET_SIZE; s++) begin
          checks++;
          if (bus.o_set[s] !== e[s]) begin
            failures++;
            $display("FAIL pulse%0d_k%0d_slot%0d got=%0h exp=%0h",
                     t, k, s, bus.o_set[s], e[s]);
          end
        end
        checks++;
        if (bus.o_set_done !== (k == d + 2) ||
            bus.o_error !== 1'b0) begin
          failures++;
          $display("FAIL pulse%0d_done_k%0d got=%b%b exp=%b0",
                   t, k, bus.o_set_done, bus.o_error, k == d + 2);
        end
      end
    end
  endtask

  task automatic test_errors();
    string tc [6] = '{"SET", "FOO", "SET", "PULSE", "PULSE", "PULSE"};
    string ta [6] = '{"nosuch", "sig0", "sig0", "sig0", "sig0", "sig0"};
    string tv [6] = '{"1", "1", "", "1", "1", "1"};
    string td [6] = '{"", "", "", "", "5", "5"};
    string tu [6] = '{"", "", "", "ns", "sec", ""};
    for (int t = 0; t < 6; t++) begin
      issue(tc[t], ta[t], tv[t], td[t], tu[t]);
      for (int k = 1; k <= 3; k++) begin
        step();
        for (int s = 0; s < SET_SIZE; s++) begin
          checks++;
          if (bus.o_set[s] !== mdl[s]) begin
            failures++;
            $display("FAIL err%0d_k%0d_slot%0d got=%0h exp=%0h",
                     t, k, s, bus.o_set[s], mdl[s]);
          end
        end
        checks++;
        if (bus.o_set_done !== (k == 2) ||
            bus.o_error !== (k == 2)) begin
          failures++;
          $display("FAIL err%0d_flags_k%0d got=%b%b exp=%b%b",
                   t, k, bus.o_set_done, bus.o_error, k == 2, k == 2);
        end
      end
    end
  endtask

  task automatic test_busy();
    logic [SET_WIDTH-1:0] e [SET_SIZE];
    issue("PULSE", "sig0", "0x3", "20", "ns");
    for (int k = 1; k <= 26; k++) begin
      step();
      e = mdl;
      if (k <= 20) e[0] = 4'h3;
      for (int s = 0; s < SET_SIZE; s++) begin
        checks++;
        if (bus.o_set[s] !== e[s]) begin
          failures++;
          $display("FAIL busy_k%0d_slot%0d got=%0h exp=%0h",
                   k, s, bus.o_set[s], e[s]);
        end
      end
      checks++;
      if (bus.o_set_done !== (k == 22) || bus.o_error !== 1'b0) begin
        failures++;
        $display("FAIL busy_done_k%0d got=%b%b exp=%b0",
                 k, bus.o_set_done, bus.o_error, k == 22);
      end
      if (k == 5) begin
        bus.i_args[0]    = "SET";
        bus.i_args[1]    = "sig3";
        bus.i_args[2]    = "0xa";
        bus.i_args_valid = 1'b1;
      end
      if (k == 6) begin
        bus.i_args_valid = 1'b0;
        bus.i_sel_set    = 1'b0;
      end
    end
    bus.i_sel_set = 1'b1;
  endtask

  task automatic test_reset_mid_pulse();
    issue("PULSE", "sig1", "0xA", "20", "ns");
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (bus.o_set[1] !== 4'hA) begin
        failures++;
        $display("FAIL rstp_pulse_k%0d got=%0h exp=a",
                 k, bus.o_set[1]);
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int s = 0; s < SET_SIZE; s++) mdl[s] = '0;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < SET_SIZE; s++) begin
        checks++;
        if (bus.o_set[s] !== '0) begin
          failures++;
          $display("FAIL rstp_k%0d_slot%0d got=%0h exp=0",
                   k, s, bus.o_set[s]);
        end
      end
      checks++;
      if (bus.o_set_done !== 1'b0 || bus.o_error !== 1'b0) begin
        failures++;
        $display("FAIL rstp_done_k%0d got=%b%b exp=00",
                 k, bus.o_set_done, bus.o_error);
      end
      step();
    end
    issue("SET", "sig2", "3", "", "");
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (bus.o_set[2] !== 4'h3 || bus.o_set_done !== (k == 2)) begin
        failures++;
        $display("FAIL rstp_set_k%0d got=%0h/%b exp=3/%b",
                 k, bus.o_set[2], bus.o_set_done, k == 2);
      end
    end
    mdl[2] = 4'h3;
  endtask

  task automatic test_random();
    logic [SET_WIDTH-1:0] e [SET_SIZE];
    string cs, as, vs, ds, us;
    int kind, slot, v, dn, d, len;
    bit err, pulse;
    for (int it = 0; it < 40; it++) begin
      kind  = $urandom_range(0, 6);
      slot  = $urandom_range(0, SET_SIZE - 1);
      v     = $urandom_range(0, 255);
      cs    = "SET";
      as    = $sformatf("sig%0d", slot);
      vs    = $urandom_range(0, 1) ? $sformatf("0x%0h", v)
                                   : $sformatf("%0d", v);
      ds    = "";
      us    = "";
      err   = 1'b0;
      pulse = 1'b0;
      d     = 0;
      case (kind)
        2, 3, 4: begin
          cs    = "PULSE";
          pulse = 1'b1;
          if ($urandom_range(0, 1)) begin
            dn = $urandom_range(0, 9000);
            us = "ps";
          end else begin
            dn = $urandom_range(0, 9);
            us = "ns";
          end
          ds = $sformatf("%0d", dn);
          d  = cycles_of(dn, us);
        end
        5: begin
          as  = "bogus";
          err = 1'b1;
        end
        6: begin
          cs  = "PULSE";
          ds  = "3";
          us  = "fs";
          err = 1'b1;
        end
        default: ;
      endcase
      len = pulse ? d + 2 : 2;
      issue(cs, as, vs, ds, us);
      for (int k = 1; k <= len; k++) begin
        step();
        e = mdl;
        if (!err && (!pulse || k <= d))
          e[slot] = SET_WIDTH'(v);
        for (int s = 0; s < SET_SIZE; s++) begin
          checks++;
          if (bus.o_set[s] !== e[s]) begin
            failures++;
            $display("FAIL rnd%0d_k%0d_slot%0d got=%0h exp=%0h",
                     it, k, s, bus.o_set[s], e[s]);
          end
        end
        checks++;
        if (bus.o_set_done !== (k == len) ||
            bus.o_error !== (k == len && err)) begin
          failures++;
          $display("FAIL rnd%0d_flags_k%0d got=%b%b exp=%b%b",
                   it, k, bus.o_set_done, bus.o_error,
                   k == len, k == len && err);
        end
      end
      if (!err && !pulse) mdl[slot] = SET_WIDTH'(v);
    end
    step();
    checks++;
    if (bus.o_set_done !== 1'b0) begin
      failures++;
      $display("FAIL rnd_tail_done got=%b exp=0", bus.o_set_done);
    end
  endtask

  initial begin
    for (int i = 0; i < SET_SIZE; i++)
      bus.i_set_alias[i] = $sformatf("sig%0d", i);
    for (int i = 0; i < ARGS_NB; i++)
      bus.i_args[i] = "";
    bus.i_sel_set    = 1'b0;
    bus.i_args_valid = 1'b0;
    test_reset();
    test_set();
    test_pulse();
    test_errors();
    test_busy();
    test_reset_mid_pulse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
